pix_word_unpack: RTL and testbench

- Sits directly downstream of the PIX_BUFF prefetch FIFO read port, in the FIFO's rd_clk domain.
- Pops packed words (default 32 bit = two RGB565 pixels) and emits one pixel per cycle on a valid/ready stream.
- Tags each pixel with x/y coordinates and sof/eol/eof markers for the recognition pipeline.
- Throttles the FIFO through rd_en; backpressure from the pixel consumer propagates back to the FIFO.

---
 rtl/pix_word_unpack.sv | 163 ++++++++++++++++
 tb/tb_pix_word_unpack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pix_word_unpack.sv
// -----------------------------------------------------------------------------
// pix_word_unpack
//
// Purpose:
//   Sits on the read port of the pixel prefetch FIFO and, in the FIFO's read
//   clock domain, splits each popped packed word into c_IN_DATA_WIDTH /
//   c_PIX_WIDTH pixels. It emits one pixel per cycle on a valid/ready stream,
//   tagged with x/y coordinates and start-of-frame / end-of-line /
//   end-of-frame markers. Consumer backpressure throttles the FIFO via
//   fifo_rd_en.
//
// Ports:
//   clk          : single clock (the FIFO read clock)
//   rst          : asynchronous, active-high reset
//   fifo_rd_data : packed word from the FIFO
//   fifo_rd_vld  : FIFO has a word available
//   fifo_rd_en   : pop request; a word is taken when fifo_rd_vld & fifo_rd_en
//   resync       : one-cycle pulse, drops the held word and restarts at 0/0
//   pix_data     : current pixel (lane 0 = word LSBs, emitted first)
//   pix_vld      : pixel valid
//   pix_rdy      : consumer ready; pixel accepted when pix_vld & pix_rdy
//   pix_x/pix_y  : column/row of the current pixel
//   pix_sof      : pixel at x=0, y=0
//   pix_eol      : pixel at the last column
//   pix_eof      : pixel at the last column of the last row
//   frame_done   : registered pulse, the cycle after the eof pixel is accepted
// -----------------------------------------------------------------------------
module pix_word_unpack #(
   parameter int c_IN_DATA_WIDTH = 32,
   parameter int c_PIX_WIDTH     = 16,
   parameter int c_IMG_WIDTH     = 640,
   parameter int c_IMG_HEIGHT    = 480,
   parameter int c_X_WIDTH       = 11,
   parameter int c_Y_WIDTH       = 11
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [c_IN_DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                       fifo_rd_vld,
   output logic                       fifo_rd_en,
   input  logic                       resync,
   output logic [c_PIX_WIDTH-1:0]     pix_data,
   output logic                       pix_vld,
   input  logic                       pix_rdy,
   output logic [c_X_WIDTH-1:0]       pix_x,
   output logic [c_Y_WIDTH-1:0]       pix_y,
   output logic                       pix_sof,
   output logic                       pix_eol,
   output logic                       pix_eof,
   output logic                       frame_done
);

   localparam int c_RATIO      = c_IN_DATA_WIDTH / c_PIX_WIDTH;
   // A one-bit lane register is kept even for R=1; it simply stays at zero.
   localparam int c_LANE_WIDTH = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;

   localparam logic [c_LANE_WIDTH-1:0] c_LANE_LAST = c_LANE_WIDTH'(c_RATIO - 1);
   localparam logic [c_LANE_WIDTH-1:0] c_LANE_ZERO = c_LANE_WIDTH'(0);
   localparam logic [c_LANE_WIDTH-1:0] c_LANE_ONE  = c_LANE_WIDTH'(1);
   localparam logic [c_X_WIDTH-1:0]    c_X_LAST    = c_X_WIDTH'(c_IMG_WIDTH - 1);
   localparam logic [c_X_WIDTH-1:0]    c_X_ZERO    = c_X_WIDTH'(0);
   localparam logic [c_X_WIDTH-1:0]    c_X_ONE     = c_X_WIDTH'(1);
   localparam logic [c_Y_WIDTH-1:0]    c_Y_LAST    = c_Y_WIDTH'(c_IMG_HEIGHT - 1);
   localparam logic [c_Y_WIDTH-1:0]    c_Y_ZERO    = c_Y_WIDTH'(0);
   localparam logic [c_Y_WIDTH-1:0]    c_Y_ONE     = c_Y_WIDTH'(1);

   logic [c_IN_DATA_WIDTH-1:0] word_r;
   logic                       hold_vld_r;
   logic [c_LANE_WIDTH-1:0]    lane_r;
   logic [c_X_WIDTH-1:0]       x_r;
   logic [c_Y_WIDTH-1:0]       y_r;
   logic                       frame_done_r;

   logic                       acc_s;
   logic                       last_s;
   logic                       rd_en_s;
   logic                       pop_s;
   logic                       x_last_s;
   logic                       y_last_s;
   logic                       eof_s;
   logic [c_PIX_WIDTH-1:0]     pix_data_s;

   // Handshake decode: accept, last lane, FIFO pop and position markers.
   always_comb begin
      acc_s    = hold_vld_r & pix_rdy;
      last_s   = (lane_r == c_LANE_LAST);
      // Pop when nothing is held, or when the last lane leaves this cycle so
      // the next word lands without a bubble. resync suppresses the pop.
      rd_en_s  = ~resync & (~hold_vld_r | (acc_s & last_s));
      pop_s    = fifo_rd_vld & rd_en_s;
      x_last_s = (x_r == c_X_LAST);
      y_last_s = (y_r == c_Y_LAST);
      eof_s    = hold_vld_r & x_last_s & y_last_s;
   end

   // Lane select: pick the c_PIX_WIDTH slice of the held word addressed by lane_r.
   always_comb begin
      pix_data_s = word_r[c_PIX_WIDTH-1:0];
      for (int i = 1; i < c_RATIO; i++) begin
         pix_data_s = (lane_r == c_LANE_WIDTH'(i)) ?
                      word_r[i*c_PIX_WIDTH +: c_PIX_WIDTH] : pix_data_s;
      end
   end

   // Held word, lane pointer, coordinate counters and frame_done pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_r       <= {c_IN_DATA_WIDTH{1'b0}};
         hold_vld_r   <= 1'b0;
         lane_r       <= c_LANE_ZERO;
         x_r          <= c_X_ZERO;
         y_r          <= c_Y_ZERO;
         frame_done_r <= 1'b0;
      end else if (resync) begin
         // resync outranks everything: any accept this cycle is discarded.
         hold_vld_r   <= 1'b0;
         lane_r       <= c_LANE_ZERO;
         x_r          <= c_X_ZERO;
         y_r          <= c_Y_ZERO;
         frame_done_r <= 1'b0;
      end else begin
         // A pop on the last-lane accept reloads rather than clears.
         if (pop_s) begin
            word_r     <= fifo_rd_data;
            hold_vld_r <= 1'b1;
            lane_r     <= c_LANE_ZERO;
         end else if (acc_s) begin
            if (last_s) begin
               hold_vld_r <= 1'b0;
               lane_r     <= c_LANE_ZERO;
            end else begin
               lane_r <= lane_r + c_LANE_ONE;
            end
         end

         if (acc_s) begin
            if (x_last_s) begin
               x_r <= c_X_ZERO;
               y_r <= y_last_s ? c_Y_ZERO : (y_r + c_Y_ONE);
            end else begin
               x_r <= x_r + c_X_ONE;
            end
         end

         frame_done_r <= acc_s & eof_s;
      end
   end

   // Output mapping: everything except fifo_rd_en comes straight from registers.
   always_comb begin
      fifo_rd_en = rd_en_s;
      pix_vld    = hold_vld_r;
      pix_data   = pix_data_s;
      pix_x      = x_r;
      pix_y      = y_r;
      // Markers are gated by hold_vld so that idle/reset shows all-zero outputs.
      pix_sof    = hold_vld_r & (x_r == c_X_ZERO) & (y_r == c_Y_ZERO);
      pix_eol    = hold_vld_r & x_last_s;
      pix_eof    = eof_s;
      frame_done = frame_done_r;
   end

endmodule

// File: tb/tb_pix_word_unpack.sv
// -----------------------------------------------------------------------------
// tb_pix_word_unpack
//
// Purpose:
//   Directed, table-driven check of pix_word_unpack. Instance A uses two
//   pixels per word on a 4x2 image; instance B uses one pixel per word on a
//   2x1 image. Each table row holds the inputs for one cycle and the outputs
//   expected in that cycle; rows are applied at the falling edge.
// -----------------------------------------------------------------------------
module tb_pix_word_unpack;

   typedef struct {
      logic        dut;      // 0 = instance A (R=2), 1 = instance B (R=1)
      logic        rst;
      logic        resync;
      logic        vld;
      logic [31:0] data;
      logic        rdy;
      logic        e_vld;
      logic [15:0] e_data;
      logic [2:0]  e_x;
      logic [1:0]  e_y;
      logic [4:0]  e_flags;  // {sof, eol, eof, frame_done, fifo_rd_en}
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: 32-bit word, 16-bit pixel, 4x2 image
   logic        a_rst = 1'b1, a_resync = 1'b0, a_vld = 1'b0, a_rdy = 1'b0;
   logic [31:0] a_data = 32'h0;
   logic        a_rd_en, a_pvld, a_sof, a_eol, a_eof, a_fd;
   logic [15:0] a_pdata;
   logic [2:0]  a_x;
   logic [1:0]  a_y;

   // Instance B: 16-bit word, 16-bit pixel, 2x1 image
   logic        b_rst = 1'b1, b_resync = 1'b0, b_vld = 1'b0, b_rdy = 1'b0;
   logic [15:0] b_data = 16'h0;
   logic        b_rd_en, b_pvld, b_sof, b_eol, b_eof, b_fd;
   logic [15:0] b_pdata;
   logic [1:0]  b_x;
   logic [0:0]  b_y;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vq[$];

   pix_word_unpack #(
      .c_IN_DATA_WIDTH(32), .c_PIX_WIDTH(16), .c_IMG_WIDTH(4),
      .c_IMG_HEIGHT(2), .c_X_WIDTH(3), .c_Y_WIDTH(2)
   ) u_dut_a (
      .clk(clk), .rst(a_rst), .fifo_rd_data(a_data), .fifo_rd_vld(a_vld),
      .fifo_rd_en(a_rd_en), .resync(a_resync), .pix_data(a_pdata),
      .pix_vld(a_pvld), .pix_rdy(a_rdy), .pix_x(a_x), .pix_y(a_y),
      .pix_sof(a_sof), .pix_eol(a_eol), .pix_eof(a_eof), .frame_done(a_fd)
   );

   pix_word_unpack #(
      .c_IN_DATA_WIDTH(16), .c_PIX_WIDTH(16), .c_IMG_WIDTH(2),
      .c_IMG_HEIGHT(1), .c_X_WIDTH(2), .c_Y_WIDTH(1)
   ) u_dut_b (
      .clk(clk), .rst(b_rst), .fifo_rd_data(b_data), .fifo_rd_vld(b_vld),
      .fifo_rd_en(b_rd_en), .resync(b_resync), .pix_data(b_pdata),
      .pix_vld(b_pvld), .pix_rdy(b_rdy), .pix_x(b_x), .pix_y(b_y),
      .pix_sof(b_sof), .pix_eol(b_eol), .pix_eof(b_eof), .frame_done(b_fd)
   );

   function automatic vec_t mk(input logic dut, input logic rst, input logic rs,
                               input logic vld, input logic [31:0] d,
                               input logic rdy, input logic ev,
                               input logic [15:0] ed, input int ex, input int ey,
                               input logic [4:0] fl);
      vec_t v;
      v.dut = dut; v.rst = rst; v.resync = rs; v.vld = vld; v.data = d;
      v.rdy = rdy; v.e_vld = ev; v.e_data = ed; v.e_x = ex[2:0];
      v.e_y = ey[1:0]; v.e_flags = fl;
      return v;
   endfunction

   // Drive one row at the falling edge, then compare 1 ns later.
   task automatic apply(input vec_t v, input int idx);
      logic [26:0] act, exp;
      @(negedge clk);
      if (v.dut == 1'b0) begin
         a_rst = v.rst; a_resync = v.resync; a_vld = v.vld;
         a_data = v.data; a_rdy = v.rdy; b_rst = 1'b1;
      end else begin
         b_rst = v.rst; b_resync = v.resync; b_vld = v.vld;
         b_data = v.data[15:0]; b_rdy = v.rdy; a_rst = 1'b1;
      end
      #1;
      if (v.dut == 1'b0)
         act = {a_pvld, (a_pvld ? a_pdata : 16'h0), a_x, a_y,
                a_sof, a_eol, a_eof, a_fd, a_rd_en};
      else
         act = {b_pvld, (b_pvld ? b_pdata : 16'h0), 1'b0, b_x, 1'b0, b_y,
                b_sof, b_eol, b_eof, b_fd, b_rd_en};
      exp = {v.e_vld, (v.e_vld ? v.e_data : 16'h0), v.e_x, v.e_y, v.e_flags};
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL row%0d {vld,data,x,y,sof,eol,eof,fd,rd_en}: actual %h required %h",
                  idx, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   initial begin
      // Reset state of A
      vq.push_back(mk(0,1,0,0,32'h0,0,        0,16'h0,0,0,5'b00001));
      // 1: back-to-back words, pix_rdy=1
      vq.push_back(mk(0,0,0,1,32'h2222_1111,1, 0,16'h0,0,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,1, 1,16'h1111,0,0,5'b10000));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,1, 1,16'h2222,1,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,1, 1,16'h3333,2,0,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,1, 1,16'h4444,3,0,5'b01001));
      vq.push_back(mk(0,0,0,1,32'h8888_7777,1, 1,16'h5555,0,1,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h8888_7777,1, 1,16'h6666,1,1,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h7777,2,1,5'b00000));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h8888,3,1,5'b01101));
      vq.push_back(mk(0,0,0,0,32'h0,1,        0,16'h0,0,0,5'b00011));
      vq.push_back(mk(0,0,0,0,32'h0,1,        0,16'h0,0,0,5'b00001));
      // 2: same frame with pix_rdy alternating
      vq.push_back(mk(0,0,0,1,32'h2222_1111,1, 0,16'h0,0,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,0, 1,16'h1111,0,0,5'b10000));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,1, 1,16'h1111,0,0,5'b10000));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,0, 1,16'h2222,1,0,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,1, 1,16'h2222,1,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,0, 1,16'h3333,2,0,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,1, 1,16'h3333,2,0,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,0, 1,16'h4444,3,0,5'b01000));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,1, 1,16'h4444,3,0,5'b01001));
      vq.push_back(mk(0,0,0,1,32'h8888_7777,0, 1,16'h5555,0,1,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h8888_7777,1, 1,16'h5555,0,1,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h8888_7777,0, 1,16'h6666,1,1,5'b00000));
      vq.push_back(mk(0,0,0,1,32'h8888_7777,1, 1,16'h6666,1,1,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,0,        1,16'h7777,2,1,5'b00000));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h7777,2,1,5'b00000));
      vq.push_back(mk(0,0,0,0,32'h0,0,        1,16'h8888,3,1,5'b01100));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h8888,3,1,5'b01101));
      vq.push_back(mk(0,0,0,0,32'h0,0,        0,16'h0,0,0,5'b00011));
      vq.push_back(mk(0,0,0,0,32'h0,0,        0,16'h0,0,0,5'b00001));
      // 3: FIFO empty after the first word for 5 cycles
      vq.push_back(mk(0,0,0,1,32'h2222_1111,1, 0,16'h0,0,0,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h1111,0,0,5'b10000));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h2222,1,0,5'b00001));
      for (int i = 0; i < 5; i++)
         vq.push_back(mk(0,0,0,0,32'h0,1,     0,16'h0,2,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,1, 0,16'h0,2,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,1, 1,16'h3333,2,0,5'b00000));
      // 4: resync while lane 1 (0x4444) is presented and accepted
      vq.push_back(mk(0,0,1,1,32'h6666_5555,1, 1,16'h4444,3,0,5'b01000));
      vq.push_back(mk(0,0,0,1,32'h6666_5555,1, 0,16'h0,0,0,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h5555,0,0,5'b10000));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h6666,1,0,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,1,        0,16'h0,2,0,5'b00001));
      // 5: reset mid-line while a word is held, checked before any clock edge
      vq.push_back(mk(0,0,0,1,32'h2222_1111,1, 0,16'h0,2,0,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h1111,2,0,5'b00000));
      vq.push_back(mk(0,1,0,0,32'h0,0,        0,16'h0,0,0,5'b00001));
      vq.push_back(mk(0,0,0,1,32'h4444_3333,1, 0,16'h0,0,0,5'b00001));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h3333,0,0,5'b10000));
      vq.push_back(mk(0,0,0,0,32'h0,1,        1,16'h4444,1,0,5'b00001));
      // 6: R=1 pass-through, 2x1 image
      vq.push_back(mk(1,1,0,0,32'h0,0,        0,16'h0,0,0,5'b00001));
      vq.push_back(mk(1,0,0,1,32'h0000_AAAA,1, 0,16'h0,0,0,5'b00001));
      vq.push_back(mk(1,0,0,1,32'h0000_BBBB,1, 1,16'hAAAA,0,0,5'b10001));
      vq.push_back(mk(1,0,0,0,32'h0,1,        1,16'hBBBB,1,0,5'b01101));
      vq.push_back(mk(1,0,0,0,32'h0,1,        0,16'h0,0,0,5'b00011));
      vq.push_back(mk(1,0,0,0,32'h0,1,        0,16'h0,0,0,5'b00001));

      for (int i = 0; i < vq.size(); i++)
         apply(vq[i], i);

      // Hand sequence: reset asserted shortly after a rising edge, not at the
      // falling edge, while a word is held and stalled.
      @(negedge clk);
      b_rst = 1'b1; a_rst = 1'b0; a_resync = 1'b0;
      a_vld = 1'b1; a_data = 32'h1234_5678; a_rdy = 1'b0;
      @(negedge clk);
      check1("held_lane0", {15'h0, a_pvld, a_pdata}, {15'h0, 1'b1, 16'h5678});
      check1("stall_rd_en", {31'h0, a_rd_en}, 32'h0);
      @(posedge clk);
      #2 a_rst = 1'b1;
      #1;
      check1("async_rst", {26'h0, a_pvld, a_x, a_y, a_rd_en},
             {26'h0, 1'b0, 3'd0, 2'd0, 1'b1});
      @(negedge clk);
      a_rst = 1'b0;
      @(negedge clk);
      check1("after_rst_sof", {14'h0, a_pvld, a_sof, a_pdata},
             {14'h0, 1'b1, 1'b1, 16'h5678});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
